// File: rtl/uart_slot_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_slot_bridge                                              |
// | Purpose  : Bus-master front end for the chu_uart slot. Programs the baud |
// |            divisor, polls the slot status register and turns a TX byte   |
// |            stream and an RX byte stream into slot push/pop writes, with  |
// |            round-robin fairness between the two directions.              |
// | Ports    : clk_i/reset_i    clock, async active-high reset               |
// |            dvsr_in_i        divisor value; dvsr_load_i requests rewrite  |
// |            init_done_o      divisor written at least once since reset    |
// |            tx_*             valid/ready byte stream into the UART TX FIFO|
// |            rx_*             valid/ready byte stream out of the RX FIFO   |
// |            cs_o/read_o/write_o/addr_o/wr_data_o  slot master pins        |
// |            rd_data_i        slot status: [9]=tx_full [8]=rx_empty [7:0]  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module uart_slot_bridge #(
  parameter int DVSR_W = 11,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DVSR_W-1:0] dvsr_in_i,
  input  logic              dvsr_load_i,
  output logic              init_done_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              cs_o,
  output logic              read_o,
  output logic              write_o,
  output logic [4:0]        addr_o,
  output logic [31:0]       wr_data_o,
  input  logic [31:0]       rd_data_i
);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_POLL   = 2'd1,
    S_RX_POP = 2'd2,
    S_TX_WR  = 2'd3
  } state_t;

  localparam logic [4:0] c_ADDR_STATUS = 5'd0;
  localparam logic [4:0] c_ADDR_DVSR   = 5'd1;
  localparam logic [4:0] c_ADDR_PUSH   = 5'd2;
  localparam logic [4:0] c_ADDR_POP    = 5'd3;

  state_t              state_q, state_d;
  logic                cs_q, cs_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [4:0]          addr_q, addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                init_done_q, init_done_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                prefer_rx_q, prefer_rx_d;
  logic                load_pend_q, load_pend_d;

  logic w_tx_full;
  logic w_rx_empty;
  logic w_rx_elig;
  logic w_tx_elig;
  logic w_poll;
  logic w_reprog;
  logic w_rx_go;
  logic w_tx_go;
  logic w_unused_rd;

  assign w_tx_full   = rd_data_i[9];
  assign w_rx_empty  = rd_data_i[8];
  assign w_unused_rd = ^rd_data_i[31:10];

  // The holding register is free if empty or being drained this very cycle,
  // which lets a pop and a reload overlap without a bubble.
  assign w_rx_elig = !w_rx_empty && (!rx_valid_q || rx_ready_i);
  assign w_tx_elig = tx_valid_i && !w_tx_full;
  assign w_poll    = (state_q == S_POLL);
  assign w_reprog  = w_poll && (dvsr_load_i || load_pend_q);
  assign w_rx_go   = w_poll && !w_reprog && w_rx_elig && (!w_tx_elig || prefer_rx_q);
  assign w_tx_go   = w_poll && !w_reprog && w_tx_elig && !w_rx_go;

  assign tx_ready_o = w_tx_go;

  // Slot pins are registered: each *_d value is what the bus shows while the
  // FSM sits in state_d.
  always_comb begin
    state_d     = state_q;
    cs_d        = 1'b1;
    read_d      = 1'b0;
    write_d     = 1'b0;
    addr_d      = c_ADDR_STATUS;
    wr_data_d   = 32'd0;
    init_done_d = init_done_q;
    prefer_rx_d = prefer_rx_q;
    load_pend_d = load_pend_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;

    case (state_q)
      S_INIT: begin
        // Straight out of reset the write has not been issued yet (write_q=0);
        // entering from S_POLL it was issued on the transition edge.
        if (write_q) begin
          state_d     = S_POLL;
          init_done_d = 1'b1;
          read_d      = 1'b1;
        end else begin
          write_d   = 1'b1;
          addr_d    = c_ADDR_DVSR;
          wr_data_d = 32'(dvsr_in_i);
        end
      end
      S_POLL: begin
        if (w_reprog) begin
          state_d     = S_INIT;
          write_d     = 1'b1;
          addr_d      = c_ADDR_DVSR;
          wr_data_d   = 32'(dvsr_in_i);
          load_pend_d = 1'b0;
        end else if (w_rx_go) begin
          state_d     = S_RX_POP;
          write_d     = 1'b1;
          addr_d      = c_ADDR_POP;
          prefer_rx_d = 1'b0;
        end else if (w_tx_go) begin
          // The write-data register doubles as the TX holding register.
          state_d     = S_TX_WR;
          write_d     = 1'b1;
          addr_d      = c_ADDR_PUSH;
          wr_data_d   = 32'(tx_data_i);
          prefer_rx_d = 1'b1;
        end else begin
          read_d = 1'b1;
        end
      end
      S_RX_POP, S_TX_WR: begin
        state_d = S_POLL;
        read_d  = 1'b1;
        if (dvsr_load_i) begin
          load_pend_d = 1'b1;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    if (w_rx_go) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rd_data_i[DATA_W-1:0];
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_INIT;
      cs_q        <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 5'd0;
      wr_data_q   <= 32'd0;
      init_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      prefer_rx_q <= 1'b1;
      load_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_q        <= cs_d;
      read_q      <= read_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      init_done_q <= init_done_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      prefer_rx_q <= prefer_rx_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign cs_o        = cs_q;
  assign read_o      = read_q;
  assign write_o     = write_q;
  assign addr_o      = addr_q;
  assign wr_data_o   = wr_data_q;
  assign init_done_o = init_done_q;
  assign rx_valid_o  = rx_valid_q;
  assign rx_data_o   = rx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_slot_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_slot_bridge                                           |
// | Purpose  : Self-checking bench for uart_slot_bridge. A small UART slot    |
// |            model (RX FIFO queue, tx_full flag) answers status reads; an   |
// |            action-level model predicts every bus cycle.                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_slot_bridge;

  localparam int P_IDLE = 0;
  localparam int P_DVSR = 1;
  localparam int P_POLL = 2;
  localparam int P_POP  = 3;
  localparam int P_PUSH = 4;
  localparam logic [63:0] c_ALT = "RTRTRTRT";

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] dvsr_in;
  logic        dvsr_load;
  logic        init_done;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  always #5 clk = ~clk;

  uart_slot_bridge #(.DVSR_W(11), .DATA_W(8)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .dvsr_in_i   (dvsr_in),
    .dvsr_load_i (dvsr_load),
    .init_done_o (init_done),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .cs_o        (cs),
    .read_o      (read),
    .write_o     (write),
    .addr_o      (addr),
    .wr_data_o   (wr_data),
    .rd_data_i   (rd_data)
  );

  // model state
  int          m_phase;
  logic        m_init, m_hold_v, m_pref_rx, m_pend, m_full;
  logic [7:0]  m_hold_d, m_push_byte;
  logic [10:0] m_dvsr;
  logic [7:0]  rx_q[$];
  logic [7:0]  delivered[$];

  // observations
  int          tests = 0;
  int          fails = 0;
  logic        s_tx_ready;
  logic [7:0]  s_rx_data;
  logic [63:0] act_log;
  int          act_cnt, n_push, n_pop;

  logic [7:0] tx_bytes [4] = '{8'h71, 8'h72, 8'h73, 8'h74};
  logic [7:0] exp_rx   [8] = '{8'h41, 8'h11, 8'h22, 8'h61, 8'h62, 8'h63, 8'h64, 8'h99};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase   = P_IDLE;
    m_init    = 1'b0;
    m_hold_v  = 1'b0;
    m_hold_d  = 8'h00;
    m_pref_rx = 1'b1;
    m_pend    = 1'b0;
  endtask

  // One bus cycle: present slot status, predict, compare, advance the model.
  task automatic step();
    logic [39:0] exp_slot, mask;
    logic        exp_txr, rx_el, tx_el;
    int          kind; // 0 none, 1 rx, 2 tx, 3 reprogram
    if (reset) model_reset();
    rd_data = {22'd0, m_full, (rx_q.size() == 0), (rx_q.size() != 0) ? rx_q[0] : 8'h00};
    #1;
    exp_txr = 1'b0;
    kind    = 0;
    mask    = {40{1'b1}};
    exp_slot = 40'd0;
    case (m_phase)
      P_DVSR: exp_slot = {1'b1, 1'b0, 1'b1, 5'd1, 21'd0, m_dvsr};
      P_POP: begin
        exp_slot = {1'b1, 1'b0, 1'b1, 5'd3, 32'd0};
        mask     = 40'hFF_0000_0000;
      end
      P_PUSH: exp_slot = {1'b1, 1'b0, 1'b1, 5'd2, 24'd0, m_push_byte};
      P_POLL: begin
        exp_slot = {1'b1, 1'b1, 1'b0, 5'd0, 32'd0};
        mask     = 40'hFF_0000_0000;
        rx_el = (rx_q.size() != 0) && (!m_hold_v || rx_ready);
        tx_el = tx_valid && !m_full;
        if (dvsr_load || m_pend)          kind = 3;
        else if (rx_el && (!tx_el || m_pref_rx)) kind = 1;
        else if (tx_el)                   kind = 2;
        exp_txr = (kind == 2);
      end
      default: exp_slot = 40'd0;
    endcase

    chk("slot_bus", 64'({cs, read, write, addr, wr_data} & mask), 64'(exp_slot & mask));
    chk("tx_ready", 64'(tx_ready), 64'(exp_txr));
    chk("rx_valid", 64'(rx_valid), 64'(m_hold_v));
    chk("rx_data", 64'(rx_data), 64'(m_hold_d));
    chk("init_done", 64'(init_done), 64'(m_init));

    s_tx_ready = tx_ready;
    s_rx_data  = rx_data;
    if (write && addr == 5'd3) begin act_log = {act_log[55:0], 8'h52}; act_cnt++; n_pop++; end
    if (write && addr == 5'd2) begin act_log = {act_log[55:0], 8'h54}; act_cnt++; n_push++; end
    if (rx_valid && rx_ready) delivered.push_back(rx_data);

    if (!reset) begin
      if (kind == 1) begin
        m_hold_v  = 1'b1;
        m_hold_d  = rx_q[0];
        m_pref_rx = 1'b0;
      end else if (m_hold_v && rx_ready) begin
        m_hold_v = 1'b0;
      end
      case (m_phase)
        P_IDLE: begin m_dvsr = dvsr_in; m_phase = P_DVSR; end
        P_DVSR: begin m_init = 1'b1; m_phase = P_POLL; end
        P_POP: begin
          if (rx_q.size() != 0) void'(rx_q.pop_front());
          if (dvsr_load) m_pend = 1'b1;
          m_phase = P_POLL;
        end
        P_PUSH: begin
          if (dvsr_load) m_pend = 1'b1;
          m_phase = P_POLL;
        end
        default: begin
          if (kind == 3) begin
            m_pend = 1'b0; m_dvsr = dvsr_in; m_phase = P_DVSR;
          end else if (kind == 1) begin
            m_phase = P_POP;
          end else if (kind == 2) begin
            m_pref_rx = 1'b1; m_push_byte = tx_data; m_phase = P_PUSH;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    int   pops0, push0, ti, guard;
    logic txr_seen;
    reset = 1'b1; dvsr_in = 11'd650; dvsr_load = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0; rd_data = 32'd0;
    m_full = 1'b0; m_push_byte = 8'h00; m_dvsr = 11'd0;
    act_log = '0; act_cnt = 0; n_push = 0; n_pop = 0;
    s_tx_ready = 1'b0; s_rx_data = 8'h00;
    model_reset();
    @(negedge clk);

    // reset state
    chk("rst_strobes", 64'({cs, read, write, addr}), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_flags", 64'({init_done, rx_valid, rx_data}), 64'd0);
    step();
    reset = 1'b0;
    step();
    // divisor write right after release
    chk("init_wr", 64'({cs, read, write, addr}), 64'({1'b1, 1'b0, 1'b1, 5'd1}));
    chk("init_dvsr", 64'(wr_data), 64'd650);
    step();
    chk("init_done_poll", 64'({init_done, read, addr}), 64'({1'b1, 1'b1, 5'd0}));

    // single RX byte
    rx_q.push_back(8'h41); rx_ready = 1'b1;
    step();
    chk("rx41_data", 64'({rx_valid, rx_data}), 64'({1'b1, 8'h41}));
    chk("rx41_pop", 64'({write, addr}), 64'({1'b1, 5'd3}));
    step();
    chk("rx41_repoll", 64'({read, write, addr}), 64'({1'b1, 1'b0, 5'd0}));

    // single TX byte
    tx_valid = 1'b1; tx_data = 8'h5A;
    step();
    chk("tx5a_ready", 64'(s_tx_ready), 64'd1);
    tx_valid = 1'b0;
    chk("tx5a_push", 64'({write, addr, wr_data}), 64'({1'b1, 5'd2, 32'h0000_005A}));
    step();
    step();
    chk("tx5a_ready_drop", 64'(s_tx_ready), 64'd0);

    // TX FIFO full for 10 cycles
    m_full = 1'b1; tx_valid = 1'b1; tx_data = 8'hA7;
    push0 = n_push; txr_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      txr_seen = txr_seen | s_tx_ready;
    end
    chk("full_no_ready", 64'(txr_seen), 64'd0);
    chk("full_no_push", 64'(n_push - push0), 64'd0);
    m_full = 1'b0;
    step();
    tx_valid = 1'b0;
    step();
    step();

    // consumer stall
    rx_ready = 1'b0; rx_q.push_back(8'h11);
    step();
    rx_q.push_back(8'h22);
    step();
    pops0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_rx_hold", 64'(s_rx_data), 64'h11);
    end
    chk("stall_no_pop", 64'(n_pop - pops0), 64'd0);
    rx_ready = 1'b1;
    step();
    chk("stall_reload", 64'({rx_valid, rx_data, write, addr}), 64'({1'b1, 8'h22, 1'b1, 5'd3}));
    step();
    step();

    // reset during a TX FIFO write
    tx_valid = 1'b1; tx_data = 8'hC3;
    step();
    tx_valid = 1'b0;
    chk("pre_rst_push", 64'({write, addr}), 64'({1'b1, 5'd2}));
    reset = 1'b1;
    #1;
    chk("async_rst_drop", 64'({cs, write, tx_ready}), 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("rst_redvsr", 64'({write, addr, wr_data}), 64'({1'b1, 5'd1, 32'd650}));
    step();

    // fair alternation with both sides continuously eligible
    rx_q.push_back(8'h61); rx_q.push_back(8'h62); rx_q.push_back(8'h63); rx_q.push_back(8'h64);
    rx_ready = 1'b1; act_log = '0; act_cnt = 0; ti = 0; guard = 0;
    while (act_cnt < 8 && guard < 40) begin
      tx_valid = (ti < 4);
      tx_data  = (ti < 4) ? tx_bytes[ti] : 8'h00;
      step();
      guard++;
      if (s_tx_ready) ti++;
    end
    tx_valid = 1'b0;
    chk("alt_count", 64'(act_cnt), 64'd8);
    chk("alt_order", act_log, c_ALT);

    // divisor reload requested during an RX pop
    rx_q.push_back(8'h99);
    step();
    dvsr_load = 1'b1; dvsr_in = 11'd100;
    step();
    dvsr_load = 1'b0;
    chk("pend_poll_first", 64'({read, write}), 64'({1'b1, 1'b0}));
    step();
    chk("pend_redvsr", 64'({write, addr, wr_data}), 64'({1'b1, 5'd1, 32'd100}));
    chk("pend_init_kept", 64'(init_done), 64'd1);
    step();
    step();
    step();

    // end-to-end byte accounting
    chk("rx_count", 64'(delivered.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < delivered.size()) chk("rx_order", 64'(delivered[i]), 64'(exp_rx[i]));
    end
    chk("tx_push_count", 64'(n_push), 64'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_slot_bridge.md
Name: uart_slot_bridge

Overview:
- Bus-master stage that sits directly upstream of the chu_uart slot interface and drives its cs/read/write/addr/wr_data pins.
- Converts two valid/ready byte streams into slot transactions:
  - a TX stream from the system, written into the UART TX FIFO;
  - an RX stream delivered to a consumer, popped from the UART RX FIFO.
- Programs the baud divisor after reset and on request, then polls status and arbitrates RX and TX fairly.

Parameters:
- DVSR_W, 11, width of the baud divisor value written to slot register 1.
- DATA_W, 8, byte width of the TX and RX streams.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dvsr_in  in  DVSR_W  divisor value to program
- dvsr_load  in  1  one-cycle request to reprogram the divisor
- init_done  out  1  high once the divisor has been written at least once since reset
- tx_data  in  DATA_W  byte to transmit
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  byte accepted this cycle when tx_valid is also high
- rx_data  out  DATA_W  received byte
- rx_valid  out  1  rx_data is valid
- rx_ready  in  1  consumer takes rx_data
- cs  out  1  slot chip select
- read  out  1  slot read strobe
- write  out  1  slot write strobe
- addr  out  5  slot register address
- wr_data  out  32  slot write data
- rd_data  in  32  slot read data, combinational: [9]=tx_full, [8]=rx_empty, [7:0]=RX FIFO head

Behaviour:
- Slot register map (addr[1:0]): 0 = status/read, 1 = write divisor, 2 = push TX FIFO, 3 = pop RX FIFO.
- Reset values: state=S_INIT; cs, read, write, addr, wr_data, tx_ready, rx_valid, init_done all 0; rx_data=0; RX/TX round-robin pointer prefers RX.
- FSM states and transitions:
  - S_INIT: drive cs=1, write=1, addr=1, wr_data={zero-pad, dvsr_in}. Next cycle: init_done<=1, go to S_POLL.
  - S_POLL: drive cs=1, read=1, addr=0; sample rd_data in the same cycle. Choose one action, in this priority order:
    - (a) dvsr_load=1: go to S_INIT. No handshake this cycle.
    - (b) RX eligible: rx_empty=0 and the holding register is free (rx_valid=0, or rx_ready=1 this cycle).
    - (c) TX eligible: tx_valid=1 and tx_full=0.
    - If both RX and TX are eligible, the round-robin pointer picks. The pointer flips to the other side after each serviced action.
  - RX chosen: rx_data<=rd_data[7:0], rx_valid<=1, go to S_RX_POP.
  - TX chosen: tx_ready=1 combinationally this cycle, tx_data latched into tx_hold, go to S_TX_WR.
  - Neither chosen: stay in S_POLL.
  - S_RX_POP: drive cs=1, write=1, addr=3. Return to S_POLL.
  - S_TX_WR: drive cs=1, write=1, addr=2, wr_data={24'b0, tx_hold}. Return to S_POLL.
- Outside the states listed, cs/read/write are 0.
- Exactly one slot strobe is active per cycle. read and write are never both high.
- tx_ready is high only in S_POLL when TX is chosen. tx_ready is never high while in S_INIT.
- RX holding register:
  - rx_valid clears on rx_valid&&rx_ready, unless a new byte loads in the same cycle; in that case rx_valid stays 1 with the new data.
  - rx_data holds its value while rx_valid=1 and rx_ready=0.
- Throughput: at most one byte per 2 cycles. Under sustained traffic in both directions, RX and TX alternate.
- Boundary cases:
  - tx_full=1: TX is never serviced and tx_ready stays 0.
  - rx_empty=1: no pop is issued.
  - Consumer stalled: no pop is issued, so RX bytes stay in the UART FIFO and none are lost.
- dvsr_load arriving in S_RX_POP or S_TX_WR is registered as pending and honoured at the next S_POLL.
- init_done stays 1 across reprogramming.
- Reset asserted mid-transaction: all strobes drop asynchronously and the FSM restarts in S_INIT. A TX byte already accepted but not yet written is discarded.

Test Plan:
- Reset release with dvsr_in=11'd650:
  - cycle 1: cs=1, write=1, addr=1, wr_data=32'd650;
  - cycle 2: init_done=1 and read strobe at addr 0.
- Status rd_data=32'h0000_0041 (rx not empty, byte 0x41), rx_ready=1 → rx_valid=1 with rx_data=8'h41, then a single write to addr 3, then polling resumes.
- tx_valid=1 with tx_data=8'h5A and tx_full=0:
  - tx_ready pulses for 1 cycle;
  - next cycle drives write at addr 2 with wr_data=32'h0000_005A.
  - Repeat with tx_full=1 held for 10 cycles → tx_ready stays 0 and no addr-2 write occurs.
- RX and TX both continuously eligible for 8 services → actions alternate RX, TX, RX, … starting with RX, four of each, with no starvation.
- rx_valid=1 and rx_ready=0 while status shows RX data available → no addr-3 pop and rx_data is stable. Raising rx_ready → pop and reload in the same S_POLL cycle.
- Assert reset during S_TX_WR → cs, write and tx_ready go to 0 immediately. After release, divisor is rewritten first; dvsr_load in S_RX_POP → S_INIT follows the next S_POLL.
